// File: rtl/instr_seq_fsm.sv
// Program-buffer instruction sequencer: keys instructions in field by field, then issues them in order.
// Optional single-step mode after each non-final write-back: define INSTR_SEQ_STEP_EN.
module instr_seq_fsm #(
  parameter int FIELD_W     = 4,
  parameter int NUM_FIELDS  = 4,
  parameter int PROG_DEPTH  = 8,
  parameter int RES_W       = 4,
  parameter int EXEC_CYCLES = 100000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn0,
  input  logic                          btn1,
  input  logic                          btn2,
  input  logic                          btn3,
  input  logic [FIELD_W-1:0]            switch,
  input  logic [RES_W-1:0]              result,
  input  logic                          overflow,
  output logic [NUM_FIELDS*FIELD_W-1:0] instruction,
  output logic                          issue_pulse,
  output logic                          write_pulse,
  output logic [3:0]                    led,
  output logic [NUM_FIELDS*4-1:0]       ssd,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic [$clog2(PROG_DEPTH):0]   prog_count,
  output logic                          prog_full,
  output logic                          is_overflow
);
  localparam int AW = $clog2(PROG_DEPTH);
  localparam int IW = $clog2(NUM_FIELDS);
  localparam int CW = $clog2(EXEC_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_FIELDS - 1);

`ifdef INSTR_SEQ_STEP_EN
  typedef enum logic [2:0] {IDLE, ENTRY, ISSUE, WAIT, DONE, STEP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ENTRY, ISSUE, WAIT, DONE} state_t;
`endif

  state_t state_reg, state_next;
  logic b0_prev_reg, b2_prev_reg, b3_prev_reg;
  logic b0, b2, b3;
  // Field i lives at packed position NUM_FIELDS-1-i so field 0 lands in the MSBs.
  logic [NUM_FIELDS-1:0][FIELD_W-1:0] field_reg, field_next;
  logic [NUM_FIELDS-1:0][FIELD_W-1:0] instr_reg;
  logic [NUM_FIELDS*FIELD_W-1:0]      prog_buf [PROG_DEPTH];
  logic [NUM_FIELDS*FIELD_W-1:0]      buf_wdata;
  logic                               buf_we;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [AW:0]    count_reg, count_next;
  logic [AW-1:0]  pc_reg, pc_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           warn_reg, warn_next;
  logic [RES_W-1:0] res_reg;
  logic           ovf_reg;
  logic           capture;
  logic           last_instr;

  assign b0 = btn0 & ~b0_prev_reg;
  assign b2 = btn2 & ~b2_prev_reg;
  assign b3 = btn3 & ~b3_prev_reg;
  assign prog_full  = (count_reg == (AW + 1)'(PROG_DEPTH));
  assign last_instr = ({1'b0, pc_reg} == count_reg - 1'b1);

  always_comb begin
    state_next = state_reg;
    field_next = field_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    warn_next  = warn_reg;
    buf_we     = 1'b0;
    buf_wdata  = {field_reg[NUM_FIELDS-1:1], switch};
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (b3) begin
          count_next = '0;
        end else if (b0) begin
          state_next = ENTRY;
          idx_next   = '0;
          field_next = '0;
        end else if (b2 && count_reg != '0) begin
          state_next = ISSUE;
          pc_next    = '0;
        end
      end
      ENTRY: begin
        if (b3) begin
          state_next = IDLE;
          idx_next   = '0;
          field_next = '0;
          warn_next  = 1'b0;
        end else if (b0) begin
          if (idx_reg == IDX_LAST) begin
            idx_next   = '0;
            field_next = '0;
            if (prog_full) begin
              warn_next = 1'b1;
            end else begin
              buf_we     = 1'b1;
              count_next = count_reg + 1'b1;
              warn_next  = 1'b0;
            end
          end else begin
            field_next[IDX_LAST - idx_reg] = switch;
            idx_next  = idx_reg + 1'b1;
            warn_next = 1'b0;
          end
        end else if (b2 && idx_reg == '0 && count_reg != '0) begin
          state_next = ISSUE;
          pc_next    = '0;
          warn_next  = 1'b0;
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (b3) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          capture  = 1'b1;
          cnt_next = '0;
          if (last_instr) begin
            state_next = DONE;
          end else begin
`ifdef INSTR_SEQ_STEP_EN
            state_next = STEP;
`else
            pc_next    = pc_reg + 1'b1;
            state_next = ISSUE;
`endif
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (b3) begin
          state_next = IDLE;
          count_next = '0;
        end else if (b0) begin
          state_next = IDLE;
        end
      end
`ifdef INSTR_SEQ_STEP_EN
      STEP: begin
        if (b3) begin
          state_next = IDLE;
        end else if (b0) begin
          pc_next    = pc_reg + 1'b1;
          state_next = ISSUE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      b0_prev_reg <= 1'b0;
      b2_prev_reg <= 1'b0;
      b3_prev_reg <= 1'b0;
      field_reg   <= '0;
      idx_reg     <= '0;
      count_reg   <= '0;
      pc_reg      <= '0;
      cnt_reg     <= '0;
      warn_reg    <= 1'b0;
      instr_reg   <= '0;
      res_reg     <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      b0_prev_reg <= btn0;
      b2_prev_reg <= btn2;
      b3_prev_reg <= btn3;
      field_reg   <= field_next;
      idx_reg     <= idx_next;
      count_reg   <= count_next;
      pc_reg      <= pc_next;
      cnt_reg     <= cnt_next;
      warn_reg    <= warn_next;
      // Loaded on entry to ISSUE so the word is already valid during the issue pulse.
      if (state_next == ISSUE) instr_reg <= prog_buf[pc_next];
      if (capture) begin
        res_reg <= result;
        ovf_reg <= overflow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) prog_buf[count_reg[AW-1:0]] <= buf_wdata;
  end

  always_comb begin
    case (state_reg)
      ENTRY:       led = warn_reg ? 4'b1010 : (4'b1000 >> idx_reg[1:0]);
      ISSUE, WAIT: led = 4'b0110;
      DONE:        led = 4'b1111;
`ifdef INSTR_SEQ_STEP_EN
      STEP:        led = 4'b0101;
`endif
      default:     led = 4'b0000;
    endcase
  end

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_digit
    localparam int P = NUM_FIELDS - 1 - gi;
    localparam logic [3:0] OVF_DIG = (gi < 4) ? 4'(10 + gi) : 4'd0;
    logic [3:0] bit_dig, dig;
    if (gi < RES_W) begin : g_bit
      assign bit_dig = {3'b000, res_reg[RES_W-1-gi]};
    end else begin : g_nobit
      assign bit_dig = 4'd0;
    end
    always_comb begin
      case (state_reg)
        ENTRY:       dig = (IW'(gi) == idx_reg) ? 4'(switch) : 4'(field_reg[P]);
        ISSUE, WAIT: dig = 4'(instr_reg[P]);
        DONE:        dig = btn1 ? 4'(instr_reg[P]) : (ovf_reg ? OVF_DIG : bit_dig);
`ifdef INSTR_SEQ_STEP_EN
        STEP:        dig = ovf_reg ? OVF_DIG : bit_dig;
`endif
        default:     dig = 4'd0;
      endcase
    end
    assign ssd[P*4 +: 4] = dig;
  end

  assign instruction = instr_reg;
  assign issue_pulse = (state_reg == ISSUE);
  assign write_pulse = capture;
  assign pc          = pc_reg;
  assign prog_count  = count_reg;
  assign is_overflow = ovf_reg;
endmodule

// File: tb/tb_instr_seq_fsm.sv
// Randomized scoreboard bench for instr_seq_fsm: a queue-based program model predicts every
// issue/write-back pair, a negedge monitor checks them, and stimulus checks status displays.
module tb_instr_seq_fsm;
  localparam int EXEC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn0 = 1'b0, btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
  logic [3:0]  switch = '0;
  logic [3:0]  result = '0;
  logic        overflow = 1'b0;
  logic [15:0] instruction;
  logic        issue_pulse, write_pulse;
  logic [3:0]  led;
  logic [15:0] ssd;
  logic [2:0]  pc;
  logic [3:0]  prog_count;
  logic        prog_full, is_overflow;

  instr_seq_fsm #(
    .FIELD_W(4), .NUM_FIELDS(4), .PROG_DEPTH(8), .RES_W(4), .EXEC_CYCLES(EXEC)
  ) dut (
    .clk(clk), .rst(rst), .btn0(btn0), .btn1(btn1), .btn2(btn2), .btn3(btn3),
    .switch(switch), .result(result), .overflow(overflow),
    .instruction(instruction), .issue_pulse(issue_pulse), .write_pulse(write_pulse),
    .led(led), .ssd(ssd), .pc(pc), .prog_count(prog_count), .prog_full(prog_full),
    .is_overflow(is_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  pc;
    bit          first;
    bit          abort;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_prog[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int last_write_cyc = 0;
  bit pending_write = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      0: btn0 = 1'b1;
      2: btn2 = 1'b1;
      default: btn3 = 1'b1;
    endcase
    tick();
    btn0 = 1'b0; btn2 = 1'b0; btn3 = 1'b0;
    tick();
  endtask

  // Display the spec assigns to a captured result: binary digits MSB first, or O,V,F,L.
  function automatic logic [15:0] exp_res_ssd(input logic [3:0] r, input logic o);
    logic [15:0] v;
    v = '0;
    if (o) return 16'hABCD;
    for (int d = 0; d < 4; d++) v[15-4*d -: 4] = {3'b000, r[3-d]};
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_ssd"}, ssd, 0);
    chk({tag, "_issue"}, issue_pulse, 0);
    chk({tag, "_write"}, write_pulse, 0);
    chk({tag, "_instr"}, instruction, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_count"}, prog_count, 0);
    chk({tag, "_full"}, prog_full, 0);
    chk({tag, "_ovf"}, is_overflow, 0);
  endtask

  // Enter one full instruction while in ENTRY at field index 0.
  task automatic enter_instr(input logic [15:0] ins);
    for (int f = 0; f < 4; f++) begin
      switch = ins[15-4*f -: 4];
      press(0);
    end
    switch = '0;
    #1;
    if (model_prog.size() < 8) model_prog.push_back(ins);
  endtask

  task automatic run_prog(input logic [3:0] res, input logic ovf);
    int n;
    int steps;
    result = res;
    overflow = ovf;
    foreach (model_prog[i]) exp_q.push_back('{model_prog[i], 3'(i), i == 0, 1'b0});
    steps = 0;
    n = 0;
    btn2 = 1'b1;
    tick();
    btn2 = 1'b0;
    while (led !== 4'hF && n < 400) begin
`ifdef INSTR_SEQ_STEP_EN
      if (led === 4'h5) begin
        steps++;
        chk("step_ssd", ssd, exp_res_ssd(res, ovf));
        press(0);
      end
`endif
      tick();
      n++;
    end
    chk("run_done_in_budget", n < 400, 1);
`ifdef INSTR_SEQ_STEP_EN
    chk("step_halts", steps, model_prog.size() - 1);
`endif
    chk("done_pc", pc, model_prog.size() - 1);
    chk("done_ssd", ssd, exp_res_ssd(res, ovf));
    chk("done_is_overflow", is_overflow, ovf);
    chk("queue_drained", exp_q.size(), 0);
    btn1 = 1'b1;
    #1;
    chk("done_show_instr", ssd, model_prog[model_prog.size() - 1]);
    btn1 = 1'b0;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending_write = 1'b0;
      end else begin
        if (issue_pulse) begin
          chk("issue_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("issue cyc=%0d pc=%0d instr=%h", cyc, pc, instruction);
            chk("issue_instr", instruction, e.instr);
            chk("issue_pc", pc, e.pc);
`ifndef INSTR_SEQ_STEP_EN
            if (!e.first) chk("issue_spacing", cyc - last_write_cyc, 1);
`endif
            issue_cyc = cyc;
            pending_write = !e.abort;
          end
        end
        if (write_pulse) begin
          $display("write cyc=%0d pc=%0d latency=%0d", cyc, pc, cyc - issue_cyc);
          chk("write_expected", pending_write, 1);
          chk("write_latency", cyc - issue_cyc, EXEC);
          chk("write_instr_stable", instruction, model_prog[pc]);
          pending_write = 1'b0;
          last_write_cyc = cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] ins;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // First instruction keyed in manually with live-digit checks.
    press(0);
    chk("entry_led_idx0", led, 4'b1000);
    switch = 4'h1;
    #1;
    chk("entry_live_digit", ssd, 16'h1000);
    press(0);
    chk("entry_led_idx1", led, 4'b0100);
    switch = 4'h2; press(0);
    switch = 4'h3; press(0);
    switch = 4'h4;
    #1;
    chk("entry_live_last", ssd, 16'h1234);
    chk("entry_led_idx3", led, 4'b0001);
    press(0);
    switch = '0;
    #1;
    model_prog.push_back(16'h1234);
    chk("entry_count1", prog_count, 1);
    chk("entry_cleared_ssd", ssd, 0);
    chk("entry_idx_back0", led, 4'b1000);
    press(3);
    chk("entry_abort_idle", led, 0);
    chk("entry_abort_keeps", prog_count, 1);
    run_prog(4'b0101, 1'b0);

    // Three random instructions, overflow reported on write-back.
    press(0);
    press(3);
    chk("idle_clear", prog_count, 0);
    model_prog.delete();
    press(0);
    for (int k = 0; k < 3; k++) begin
      ins = 16'($urandom);
      enter_instr(ins);
    end
    chk("count3", prog_count, 3);
    run_prog(4'($urandom), 1'b1);

    // Fill the buffer, then try a ninth instruction.
    press(3);
    chk("done_clear", prog_count, 0);
    model_prog.delete();
    press(0);
    for (int k = 0; k < 8; k++) begin
      ins = 16'($urandom);
      enter_instr(ins);
    end
    chk("full_flag", prog_full, 1);
    chk("full_count", prog_count, 8);
    ins = 16'($urandom);
    enter_instr(ins);
    chk("ninth_count_holds", prog_count, 8);
    chk("ninth_led_warn", led, 4'b1010);
    chk("ninth_full", prog_full, 1);
    run_prog(4'($urandom), 1'b0);

    // Held btn0 advances only once; btn3 beats btn0 in the same cycle.
    press(0);
    press(0);
    switch = 4'h7;
    btn0 = 1'b1;
    repeat (50) tick();
    btn0 = 1'b0;
    tick();
    switch = 4'h0;
    #1;
    chk("held_btn0_led", led, 4'b0100);
    chk("held_btn0_ssd", ssd, 16'h7000);
    btn0 = 1'b1; btn3 = 1'b1;
    tick();
    btn0 = 1'b0; btn3 = 1'b0;
    tick();
    chk("clear_wins_led", led, 0);
    chk("clear_wins_ssd", ssd, 0);
    chk("clear_wins_keeps", prog_count, 8);

    // Reset while waiting at exec counter 5.
    exp_q.push_back('{model_prog[0], 3'd0, 1'b1, 1'b1});
    btn2 = 1'b1;
    tick();
    btn2 = 1'b0;
    chk("abort_run_issue", issue_pulse, 1);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    model_prog.delete();
    repeat (3) tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("midrst_idle_led", led, 0);
    chk("midrst_no_write", write_pulse, 0);
    chk("midrst_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
